// File: rtl/prbs9_ber_ctrl.sv
// prbs9_ber_ctrl: PRBS9 (x^9+x^5+1) bit-error-rate checker controller.
// Flow: IDLE -> FILL (load 9 rx bits) -> SYNC (LOCK_CNT straight matches)
// -> RUN (free-running reference, count bits/errors) -> DONE.
// Optional loss-of-lock detection is compiled in with `define PRBS9_BER_LOL_EN.
module prbs9_ber_ctrl #(
  parameter logic [8:0] SEED     = 9'h1AA,
  parameter int         LOCK_CNT = 16,
  parameter int         LOSS_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_valid,
  input  logic        i_rx_bit,
  input  logic [15:0] i_test_len,
  output logic        o_gen_enable,
  output logic        o_lock,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_bit_cnt,
  output logic [7:0]  o_lol_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_SYNC = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int MW = $clog2(LOCK_CNT + 1);

  // Thresholds of zero would make the lock / loss conditions meaningless.
  if (LOCK_CNT < 1 || LOSS_CNT < 1) begin : g_bad_param
    $error("prbs9_ber_ctrl: LOCK_CNT and LOSS_CNT must be at least 1");
  end

  state_e        state_q, state_d;
  logic [8:0]    h_q, h_d;
  logic [3:0]    fill_q, fill_d;
  logic [MW-1:0] match_q, match_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   err_q, err_d;
  logic [15:0]   bit_q, bit_d;
  logic          done_q, done_d;
  logic          pred_s, mis_s, fill_last_s, lock_hit_s, len_hit_s, lol_hit_s;
  logic          lock_s, busy_s, gen_s;

  // h[0] is the newest sample, h[8] the one nine samples back.
  assign pred_s      = h_q[8] ^ h_q[4];
  assign mis_s       = i_rx_bit ^ pred_s;
  assign fill_last_s = (fill_q == 4'd8);
  assign lock_hit_s  = !mis_s && (match_q == MW'(LOCK_CNT - 1));
  assign len_hit_s   = (len_q != 16'd0) && ((bit_q + 16'd1) == len_q);

`ifdef PRBS9_BER_LOL_EN
  localparam int LW = $clog2(LOSS_CNT + 1);
  logic [LW-1:0] loss_q, loss_d;
  logic [7:0]    lol_q, lol_d;
  assign lol_hit_s = mis_s && (loss_q == LW'(LOSS_CNT - 1));
  assign o_lol_cnt = lol_q;
`else
  assign lol_hit_s = 1'b0;
  assign o_lol_cnt = 8'd0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop always wins, valid gates all data-driven progress.
  always_comb begin
    state_d = state_q;
    if (i_stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) state_d = ST_FILL;
          else         state_d = state_q;
        end
        ST_FILL: begin
          if (i_valid && fill_last_s) state_d = ST_SYNC;
          else                        state_d = state_q;
        end
        ST_SYNC: begin
          if (i_valid && lock_hit_s) state_d = ST_RUN;
          else                       state_d = state_q;
        end
        ST_RUN: begin
          if (i_valid && len_hit_s)      state_d = ST_DONE;
          else if (i_valid && lol_hit_s) state_d = ST_FILL;
          else                           state_d = state_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    lock_s = 1'b0;
    busy_s = 1'b0;
    gen_s  = 1'b0;
    case (state_q)
      ST_FILL: gen_s = 1'b1;
      ST_SYNC: begin
        busy_s = 1'b1;
        gen_s  = 1'b1;
      end
      ST_RUN: begin
        lock_s = 1'b1;
        busy_s = 1'b1;
        gen_s  = 1'b1;
      end
      default: begin
        lock_s = 1'b0;
        busy_s = 1'b0;
        gen_s  = 1'b0;
      end
    endcase
  end

  assign o_lock       = lock_s;
  assign o_busy       = busy_s;
  assign o_gen_enable = gen_s;
  assign o_done       = done_q;
  assign o_err_cnt    = err_q;
  assign o_bit_cnt    = bit_q;

  // Next values for reference history, counters and the completion pulse.
  always_comb begin
    h_d     = h_q;
    fill_d  = fill_q;
    match_d = match_q;
    len_d   = len_q;
    err_d   = err_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
`ifdef PRBS9_BER_LOL_EN
    loss_d  = loss_q;
    lol_d   = lol_q;
`endif
    if (i_stop) begin
      done_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            h_d     = SEED;
            fill_d  = 4'd0;
            match_d = {MW{1'b0}};
            len_d   = i_test_len;
            err_d   = 16'd0;
            bit_d   = 16'd0;
`ifdef PRBS9_BER_LOL_EN
            loss_d  = {LW{1'b0}};
            lol_d   = 8'd0;
`endif
          end else begin
            done_d = 1'b0;
          end
        end
        ST_FILL: begin
          if (i_valid) begin
            h_d    = {h_q[7:0], i_rx_bit};
            fill_d = fill_q + 4'd1;
          end else begin
            h_d = h_q;
          end
        end
        ST_SYNC: begin
          if (i_valid) begin
            h_d = {h_q[7:0], i_rx_bit};
            if (mis_s) match_d = {MW{1'b0}};
            else       match_d = match_q + {{(MW-1){1'b0}}, 1'b1};
`ifdef PRBS9_BER_LOL_EN
            loss_d = {LW{1'b0}};
`endif
          end else begin
            h_d = h_q;
          end
        end
        ST_RUN: begin
          if (i_valid) begin
            // Reference free-runs on its own prediction so rx errors do not echo.
            h_d   = {h_q[7:0], pred_s};
            bit_d = bit_q + 16'd1;
            if (mis_s && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
            else                              err_d = err_q;
            if (len_hit_s) done_d = 1'b1;
            else           done_d = 1'b0;
`ifdef PRBS9_BER_LOL_EN
            if (!mis_s) begin
              loss_d = {LW{1'b0}};
            end else if (lol_hit_s && !len_hit_s) begin
              loss_d  = {LW{1'b0}};
              fill_d  = 4'd0;
              match_d = {MW{1'b0}};
              if (lol_q != 8'hFF) lol_d = lol_q + 8'd1;
              else                lol_d = lol_q;
            end else begin
              loss_d = loss_q + {{(LW-1){1'b0}}, 1'b1};
            end
`endif
          end else begin
            h_d = h_q;
          end
        end
        default: done_d = 1'b0;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q     <= SEED;
      fill_q  <= 4'd0;
      match_q <= {MW{1'b0}};
      len_q   <= 16'd0;
      err_q   <= 16'd0;
      bit_q   <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      h_q     <= h_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      len_q   <= len_d;
      err_q   <= err_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

`ifdef PRBS9_BER_LOL_EN
  // Loss-of-lock tracking registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loss_q <= {LW{1'b0}};
      lol_q  <= 8'd0;
    end else begin
      loss_q <= loss_d;
      lol_q  <= lol_d;
    end
  end
`endif

endmodule
